// File: rtl/alu_seq_if.sv
// Request/result bundle between the ID/EX operand latches, the registered ALU and the EX/MEM stage.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic [3:0]       alu_ctl;
    logic             err;

    modport master (
        output in_valid, alu_op, funct, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, alu_ctl, err
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b, out_ready,
        output in_ready, out_valid, result, zero, ovf, alu_ctl, err
    );
endinterface

// File: rtl/alu_seq.sv
// Registered MIPS ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to add the multi-cycle shift-add multiply (funct 1000, BUSY state).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_ERR = 4'b1111;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] CTL_MUL = 4'b0011;
    localparam int         CNT_W   = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;
`endif

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             err_q, err_d;

    logic [3:0]       ctlDec;
    logic             errDec;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] opResult;
    logic             opOvf;
    logic             inReady;
    logic             accept;
    logic             unusedFunct;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] accNext;

    assign accNext = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign inReady = (state_q == IDLE) | ((state_q == FULL) & bus.out_ready);
`else
    assign inReady = (state_q == IDLE) | bus.out_ready;
`endif

    assign accept      = bus.in_valid & inReady;
    assign unusedFunct = &{1'b0, bus.funct[5:4]};
    assign sum         = bus.a + bus.b;
    assign diff        = bus.a - bus.b;

    // Only funct[3:0] distinguishes the supported R-type ops.
    always_comb begin
        ctlDec = CTL_ERR;
        errDec = 1'b1;
        case (bus.alu_op)
            2'b00: begin
                ctlDec = CTL_ADD;
                errDec = 1'b0;
            end
            2'b01: begin
                ctlDec = CTL_SUB;
                errDec = 1'b0;
            end
            2'b10: begin
                errDec = 1'b0;
                case (bus.funct[3:0])
                    4'b0000: ctlDec = CTL_ADD;
                    4'b0010: ctlDec = CTL_SUB;
                    4'b0100: ctlDec = CTL_AND;
                    4'b0101: ctlDec = CTL_OR;
                    4'b0111: ctlDec = CTL_NOR;
                    4'b1010: ctlDec = CTL_SLT;
`ifdef ALU_SEQ_MUL_EN
                    4'b1000: ctlDec = CTL_MUL;
`endif
                    default: errDec = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        opResult = '0;
        opOvf    = 1'b0;
        case (ctlDec)
            CTL_ADD: begin
                opResult = sum;
                opOvf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            CTL_SUB: begin
                opResult = diff;
                opOvf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            CTL_AND: opResult = bus.a & bus.b;
            CTL_OR:  opResult = bus.a | bus.b;
            CTL_NOR: opResult = ~(bus.a | bus.b);
            CTL_SLT: opResult = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new accept while FULL replaces the held result in the same edge, giving one op per cycle.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ctl_d    = ctl_q;
        err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        if (state_q == BUSY) begin
            acc_d    = accNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d  = FULL;
                result_d = accNext;
                zero_d   = (accNext == '0);
                ovf_d    = 1'b0;
                ctl_d    = CTL_MUL;
                err_d    = 1'b0;
                cnt_d    = '0;
            end
        end else
`endif
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (ctlDec == CTL_MUL) begin
                state_d  = BUSY;
                mcand_d  = bus.a;
                mplier_d = bus.b;
                acc_d    = '0;
                cnt_d    = '0;
            end else
`endif
            begin
                state_d  = FULL;
                result_d = opResult;
                zero_d   = (opResult == '0);
                ovf_d    = opOvf;
                ctl_d    = ctlDec;
                err_d    = errDec;
            end
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ctl_q    <= 4'b0000;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ctl_q    <= ctl_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == FULL);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.alu_ctl   = ctl_q;
    assign bus.err       = err_q;

endmodule
